// File: rtl/multiplexor_scan_if.sv
// Bus between the operation multiplexor side and the scan sequencer/result collector.
// The master drives the scan request, mux result and readback index; the slave drives the rest.
interface multiplexor_scan_if #(
  parameter int NUM_OPS = 6,
  parameter int WIDTH   = 16
);
  logic               start;
  logic [WIDTH-1:0]   R;
  logic               en;
  logic [2:0]         SEL;
  logic               busy;
  logic               done;
  logic [NUM_OPS-1:0] valid;
  logic               err;
  logic [2:0]         RD_SEL;
  logic [WIDTH-1:0]   Q;

  modport master (
    output start, R, en, RD_SEL,
    input  SEL, busy, done, valid, err, Q
  );

  modport slave (
    input  start, R, en, RD_SEL,
    output SEL, busy, done, valid, err, Q
  );
endinterface

// File: rtl/multiplexor_scan.sv
// Steps SEL through every operation code, waits SETTLE cycles per step, captures R into a
// per-operation bank when en is high, and pulses done at the end; the bank is read back via RD_SEL.
module multiplexor_scan #(
  parameter int NUM_OPS = 6,
  parameter int SETTLE  = 1,
  parameter int WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  multiplexor_scan_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE_WAIT,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [2:0] LAST_SEL   = 3'(NUM_OPS - 1);
  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
  // With no settle time every op goes straight to its sample cycle.
  localparam state_t     STEP_STATE = (SETTLE == 0) ? SAMPLE : SETTLE_WAIT;

  state_t           state;
  logic [3:0]       count;
  logic [WIDTH-1:0] bank [NUM_OPS];

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state     <= IDLE;
      count     <= '0;
      bus.SEL   <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.valid <= '0;
      bus.err   <= 1'b0;
      // NOTE: the bank is a small register file that must read as zero after reset, so it is
      // reset explicitly; a true RAM macro could not be cleared this way.
      for (int i = 0; i < NUM_OPS; i++) bank[i] <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.SEL   <= '0;
            bus.valid <= '0;
            bus.err   <= 1'b0;
            bus.busy  <= 1'b1;
            count     <= SETTLE_CNT;
            state     <= STEP_STATE;
          end
        end

        SETTLE_WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) state <= SAMPLE;
        end

        SAMPLE: begin
          if (bus.en) begin
            bank[bus.SEL]      <= bus.R;
            bus.valid[bus.SEL] <= 1'b1;
          end else begin
            bus.err <= 1'b1;
          end
          if (bus.SEL == LAST_SEL) begin
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            bus.SEL <= bus.SEL + 3'd1;
            count   <= SETTLE_CNT;
            state   <= STEP_STATE;
          end
        end

        DONE: begin
          bus.busy <= 1'b0;
          bus.SEL  <= '0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Zero-latency readback; indices past the last op read as zero.
  always_comb begin
    // NOTE: default first so no path leaves Q unassigned and infers a latch.
    bus.Q = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (bus.RD_SEL == 3'(i)) bus.Q = bank[i];
    end
  end

endmodule

// File: doc/multiplexor_scan.md
Name: multiplexor_scan

Overview:
- Sequencer and result collector on the consumer side of the operation multiplexor.
- On `start`, it steps `SEL` through every operation code and waits for the mux output to settle after each step.
- It captures `R` into a per-operation result bank when `en` is high.
- It reports completion with a one-cycle `done` pulse; the bank is then readable by index.

Parameters:
- `NUM_OPS`, 6: number of operation codes scanned (SEL = 0 .. NUM_OPS-1); legal range 1..8.
- `SETTLE`, 1: idle cycles after each SEL change before sampling R; legal range 0..15.
- `WIDTH`, 16: width of R and of each bank entry.

Ports:
- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous, active-high reset
- `start`  input  1  scan request; sampled only in IDLE
- `R`  input  WIDTH  result from the multiplexor
- `en`  input  1  multiplexor result-valid flag
- `SEL`  output  3  operation select driven to the multiplexor
- `busy`  output  1  high from the cycle after start is accepted until done
- `done`  output  1  one-cycle pulse when the scan completes
- `valid`  output  NUM_OPS  bit i set when entry i was captured with en=1 in the last scan
- `err`  output  1  sticky; set if en=0 at any sample point; cleared by rst or by a new start
- `RD_SEL`  input  3  readback index
- `Q`  output  WIDTH  combinational readback of bank[RD_SEL]; 0 when RD_SEL >= NUM_OPS

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - State goes to IDLE.
  - SEL=0, busy=0, done=0, valid=0, err=0, all bank entries=0, settle counter=0.
  - rst mid-scan aborts the scan with the same result; no done pulse is issued.
- States: IDLE, SETTLE_WAIT, SAMPLE, DONE.
- IDLE:
  - start=1: SEL<=0, valid<=0, err<=0, busy<=1, counter<=SETTLE. Next state is SETTLE_WAIT, or SAMPLE if SETTLE=0.
  - start=0: hold all outputs.
- SETTLE_WAIT: counter decrements each cycle; when it reaches 1 the next state is SAMPLE. Exactly SETTLE cycles are spent here per op.
- SAMPLE, one cycle:
  - en=1: bank[SEL]<=R, valid[SEL]<=1.
  - en=0: bank[SEL] unchanged, valid[SEL] stays 0, err<=1.
  - SEL < NUM_OPS-1: SEL<=SEL+1, counter<=SETTLE, next state SETTLE_WAIT (or SAMPLE if SETTLE=0).
  - SEL = NUM_OPS-1: next state DONE; SEL holds its value.
- DONE, one cycle: done=1, busy<=0, SEL<=0, next state IDLE.
- Timing:
  - start is accepted at edge t.
  - Op k is sampled at edge t+(k+1)(SETTLE+1).
  - done is high during the cycle after the last sample.
  - Total time from start edge to done-high cycle is NUM_OPS*(SETTLE+1)+1 cycles.
- start while busy or in DONE is ignored. No queuing.
- start and rst together: rst wins.
- SEL never exceeds NUM_OPS-1; there is no wrap-around within a scan.
- valid and bank contents persist after done until the next start or rst.
- Bank entries from a previous scan are not cleared on start, but their valid bits are cleared.
- Q is combinational with zero latency, decodes RD_SEL only, and is legal in any state, including mid-scan.

Test Plan:
- Reset check: hold rst 2 cycles mid-scan (SEL=3) -> next cycle SEL=0, busy=0, valid=0, err=0, Q=0 for all RD_SEL, no done pulse.
- Nominal scan, SETTLE=1, NUM_OPS=6, R driven as 16'h1000+SEL one cycle after SEL, en=1:
  - done pulses exactly 13 cycles after start.
  - valid=6'b111111, err=0.
  - RD_SEL=0..5 gives Q=16'h1000..16'h1005.
  - RD_SEL=6 and RD_SEL=7 give Q=0.
- en low on op 2: en=0 whenever SEL=2 -> valid=6'b111011, err=1, Q(RD_SEL=2) keeps its previous-scan value, done still pulses.
- start during scan: pulse start again at SEL=2 -> ignored. Single done at the nominal cycle, SEL sequence 0..5 uninterrupted.
- SETTLE=0 variant: back-to-back sampling, SEL changes every cycle -> done 7 cycles after start, all six entries captured.
- Rescan: second start immediately after done -> err clears, valid clears at accept, new R values (16'h2000+SEL) overwrite all entries.
